// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-to-binary stream counter.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WAIT  = 2'd2
  } sc_state_e;

  // One extra bit so a window of all 1s (exactly 2^LOG_WINDOW) is representable.
  function automatic int sc_cw(input int log_window);
    return log_window + 1;
  endfunction

endpackage

// File: rtl/sc_bit_counter.sv
// One per-stream ones accumulator; sum is the value after this cycle's sample.
module sc_bit_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          din,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] sum
);

  // Exposed so the final sample of a window can go straight to the output register.
  assign sum = cnt + CW'(en & din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= sum;
  end

endmodule

// File: rtl/sc_stream_counter.sv
// Counts ones on NUM_STREAMS bitstreams per 2^LOG_WINDOW-sample window and
// presents the counts through a one-deep valid/ready output register.
module sc_stream_counter
  import sc_pkg::*;
#(
  parameter int NUM_STREAMS = 16,
  parameter int LOG_WINDOW  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  continuous,
  input  logic [NUM_STREAMS-1:0]                inputStreams,
  input  logic                                  inValid,
  output logic [NUM_STREAMS*(LOG_WINDOW+1)-1:0] counts,
  output logic                                  countsValid,
  input  logic                                  countsReady,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int CW = sc_cw(LOG_WINDOW);

  sc_state_e                        state;
  logic [LOG_WINDOW-1:0]            scnt;
  logic [NUM_STREAMS-1:0][CW-1:0]   acc_cnt, acc_sum, cnt_q;

  logic take, last, accept, free, load_acc, load_wait, acc_clr;

  assign take      = (state == ST_ACCUM) && inValid;
  assign last      = take && (scnt == '1);
  assign accept    = countsValid && countsReady;
  assign free      = !countsValid || countsReady;
  assign load_acc  = last && free;
  assign load_wait = (state == ST_WAIT) && accept;
  assign acc_clr   = (state == ST_IDLE) || load_acc || load_wait;

  assign busy   = (state != ST_IDLE);
  assign counts = cnt_q;

  for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_lane
    sc_bit_counter #(.CW(CW)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (take),
      .din (inputStreams[k]),
      .cnt (acc_cnt[k]),
      .sum (acc_sum[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      scnt        <= '0;
      cnt_q       <= '0;
      countsValid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state   <= ST_ACCUM;
          overrun <= 1'b0;
        end
        // A blocked completion parks the final counts in the accumulators.
        ST_ACCUM: if (last)
          state <= free ? (continuous ? ST_ACCUM : ST_IDLE) : ST_WAIT;
        ST_WAIT: begin
          if (inValid) overrun <= 1'b1;
          if (accept)  state   <= continuous ? ST_ACCUM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Sample counter wraps to 0 on its own when a window parks in WAIT.
      if (acc_clr)   scnt <= '0;
      else if (take) scnt <= scnt + 1'b1;

      if (load_acc) begin
        cnt_q       <= acc_sum;
        countsValid <= 1'b1;
      end else if (load_wait) begin
        cnt_q       <= acc_cnt;
        countsValid <= 1'b1;
      end else if (accept) begin
        countsValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_counter.sv
// Directed bench for sc_stream_counter with NUM_STREAMS=4, LOG_WINDOW=4.
module tb_sc_stream_counter;

  localparam int NS = 4;
  localparam int LW = 4;
  localparam int CW = LW + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              continuous = 1'b0;
  logic [NS-1:0]     inputStreams = '0;
  logic              inValid = 1'b0;
  logic [NS*CW-1:0]  counts;
  logic              countsValid;
  logic              countsReady = 1'b0;
  logic              busy;
  logic              overrun;

  int passed = 0;
  int total  = 0;

  sc_stream_counter #(.NUM_STREAMS(NS), .LOG_WINDOW(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .inputStreams (inputStreams),
    .inValid      (inValid),
    .counts       (counts),
    .countsValid  (countsValid),
    .countsReady  (countsReady),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [NS*CW-1:0] pk(input int c3, input int c2, input int c1, input int c0);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  task automatic do_start();
    start   = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic consume();
    countsReady = 1'b1;
    @(negedge clk);
    countsReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++; if (counts !== '0)      $display("FAIL reset_counts got %h want 0", counts); else passed++;
    total++; if (countsValid !== 0)  $display("FAIL reset_valid got %b want 0", countsValid); else passed++;
    total++; if (busy !== 0)         $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (overrun !== 0)      $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_window();
    continuous = 1'b0;
    do_start();
    total++; if (busy !== 1) $display("FAIL single_busy got %b want 1", busy); else passed++;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++; if (countsValid !== 0) $display("FAIL single_early_valid got %b want 0", countsValid); else passed++;
      end
      inputStreams = {logic'(i < 3), logic'(i % 2 == 0), 1'b0, 1'b1};
      inValid = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL single_valid got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(3, 8, 0, 16)) $display("FAIL single_counts got %h want %h", counts, pk(3, 8, 0, 16)); else passed++;
    total++; if (busy !== 0) $display("FAIL single_idle got %b want 0", busy); else passed++;
    consume();
    total++; if (countsValid !== 0) $display("FAIL single_consumed got %b want 0", countsValid); else passed++;
  endtask

  task automatic test_gapped();
    continuous = 1'b0;
    do_start();
    for (int c = 0; c < 31; c++) begin
      if (c == 30) begin
        total++; if (countsValid !== 0) $display("FAIL gapped_early_valid got %b want 0", countsValid); else passed++;
      end
      inputStreams = {logic'(c / 2 < 3), logic'((c / 2) % 2 == 0), 1'b0, 1'b1};
      inValid = (c % 2 == 0);
      @(negedge clk);
    end
    inValid = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL gapped_valid got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(3, 8, 0, 16)) $display("FAIL gapped_counts got %h want %h", counts, pk(3, 8, 0, 16)); else passed++;
    consume();
  endtask

  task automatic test_back_to_back();
    continuous  = 1'b1;
    countsReady = 1'b1;
    do_start();
    for (int i = 0; i < 16; i++) begin
      inputStreams = 4'b0001; inValid = 1'b1;
      @(negedge clk);
    end
    total++; if (countsValid !== 1) $display("FAIL b2b_valid1 got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(0, 0, 0, 16)) $display("FAIL b2b_counts1 got %h want %h", counts, pk(0, 0, 0, 16)); else passed++;
    for (int i = 0; i < 16; i++) begin
      inputStreams = 4'b0010; inValid = 1'b1;
      if (i == 15) continuous = 1'b0;
      @(negedge clk);
      if (i == 0) begin
        total++; if (countsValid !== 0) $display("FAIL b2b_accepted got %b want 0", countsValid); else passed++;
        total++; if (busy !== 1) $display("FAIL b2b_busy got %b want 1", busy); else passed++;
      end
    end
    inValid = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL b2b_valid2 got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(0, 0, 16, 0)) $display("FAIL b2b_counts2 got %h want %h", counts, pk(0, 0, 16, 0)); else passed++;
    total++; if (busy !== 0) $display("FAIL b2b_idle got %b want 0", busy); else passed++;
    @(negedge clk);
    countsReady = 1'b0;
    total++; if (countsValid !== 0) $display("FAIL b2b_drained got %b want 0", countsValid); else passed++;
  endtask

  task automatic test_wait_overrun();
    continuous  = 1'b1;
    countsReady = 1'b0;
    do_start();
    for (int i = 0; i < 32; i++) begin
      inputStreams = (i < 16) ? 4'b0001 : 4'b0010;
      inValid = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    total++; if (busy !== 1) $display("FAIL wait_busy got %b want 1", busy); else passed++;
    total++; if (counts !== pk(0, 0, 0, 16)) $display("FAIL wait_hold got %h want %h", counts, pk(0, 0, 0, 16)); else passed++;
    total++; if (overrun !== 0) $display("FAIL wait_no_overrun got %b want 0", overrun); else passed++;
    inputStreams = 4'b1111; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    total++; if (overrun !== 1) $display("FAIL wait_overrun got %b want 1", overrun); else passed++;
    total++; if (counts !== pk(0, 0, 0, 16)) $display("FAIL wait_stable got %h want %h", counts, pk(0, 0, 0, 16)); else passed++;
    countsReady = 1'b1;
    @(negedge clk);
    countsReady = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL wait_exit_valid got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(0, 0, 16, 0)) $display("FAIL wait_exit_counts got %h want %h", counts, pk(0, 0, 16, 0)); else passed++;
    total++; if (busy !== 1) $display("FAIL wait_exit_accum got %b want 1", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    continuous = 1'b0;
    for (int i = 0; i < 7; i++) begin
      inputStreams = 4'b1111; inValid = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (counts !== '0) $display("FAIL rstmid_counts got %h want 0", counts); else passed++;
    total++; if (countsValid !== 0) $display("FAIL rstmid_valid got %b want 0", countsValid); else passed++;
    total++; if (busy !== 0) $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
    total++; if (overrun !== 0) $display("FAIL rstmid_overrun got %b want 0", overrun); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    for (int i = 0; i < 16; i++) begin
      inputStreams = 4'b1111; inValid = 1'b1;
      @(negedge clk);
    end
    inValid = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL rstmid_new_valid got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(16, 16, 16, 16)) $display("FAIL rstmid_new_counts got %h want %h", counts, pk(16, 16, 16, 16)); else passed++;
    consume();
  endtask

  task automatic test_start_ignored();
    continuous = 1'b0;
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total++; if (countsValid !== 0) $display("FAIL startign_early got %b want 0", countsValid); else passed++;
      end
      inputStreams = {1'b1, logic'(i >= 8), 1'b1, 1'b0};
      inValid = 1'b1;
      start   = (i >= 4 && i <= 6);
      @(negedge clk);
    end
    inValid = 1'b0;
    start   = 1'b0;
    total++; if (countsValid !== 1) $display("FAIL startign_valid got %b want 1", countsValid); else passed++;
    total++; if (counts !== pk(16, 8, 16, 0)) $display("FAIL startign_counts got %h want %h", counts, pk(16, 8, 16, 0)); else passed++;
    total++; if (busy !== 0) $display("FAIL startign_idle got %b want 0", busy); else passed++;
    consume();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_gapped();
    test_back_to_back();
    test_wait_overrun();
    test_reset_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/sc_stream_counter.md
# sc_stream_counter

Stochastic-to-binary conversion stage sitting directly downstream of the stochastic matrix-multiply array. It accumulates the number of 1s on each of NUM_STREAMS output bitstreams over a fixed window of 2^LOG_WINDOW valid samples. It then presents the per-stream counts as binary values through a valid/ready handshake, using a one-deep output register so the next window can accumulate while the previous result drains.

## Interface
- NUM_STREAMS, 16, number of bitstreams counted in parallel (BATCH_SIZE*OUTPUT_FEATURES of the multiply array)
- LOG_WINDOW, 8, log2 of window length in valid samples; count width CW = LOG_WINDOW+1
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a conversion; honoured only in IDLE
- continuous  input  1  sampled at each window completion; 1 = start next window automatically, 0 = return to IDLE
- inputStreams  input  NUM_STREAMS  one bit per stream per cycle; stream k on bit k
- inValid  input  1  inputStreams carries a valid sample this cycle
- counts  output  NUM_STREAMS*CW  result; stream k at counts[k*CW +: CW]
- countsValid  output  1  counts holds an unconsumed result
- countsReady  input  1  consumer accepts counts when countsValid && countsReady
- busy  output  1  high in any state other than IDLE
- overrun  output  1  sticky; a valid sample was dropped

## Operation
- States: IDLE, ACCUM, WAIT.
- IDLE: accumulators and sample counter held at 0. start=1 clears overrun and goes to ACCUM.
- ACCUM: on each cycle with inValid=1, sample counter += 1 and accumulator k += inputStreams[k]. Cycles with inValid=0 change nothing.
- Window completes on the cycle the 2^LOG_WINDOW-th valid sample is taken. Final counts include that sample and range 0..2^LOG_WINDOW with no saturation.
- At completion, if the output register is free (countsValid=0, or countsValid && countsReady this cycle):
  - final counts load into the output register;
  - accumulators and sample counter clear;
  - next state is ACCUM if continuous=1, else IDLE.
- At completion with the output register occupied and not accepted: go to WAIT and hold the final counts in the accumulators.
- WAIT: inputs are ignored. inValid=1 sets overrun. On the cycle countsValid && countsReady, the held counts load into the output register, accumulators clear, and the state goes to ACCUM (continuous=1) or IDLE.
- Output register: loaded as above. countsValid clears on accept unless reloaded the same edge. counts are stable while countsValid=1 and not accepted.
- start outside IDLE has no effect. continuous is sampled only at window completion or WAIT exit.

## Timing
- Reset values: counts=0, countsValid=0, busy=0, overrun=0, state IDLE, all accumulators 0.
- start at edge t puts the block in ACCUM from t+1. The first sample counted is the one presented in cycle t+1.
- Latency: countsValid rises the cycle after the edge that takes the last sample.
- Continuous mode with a free output register: no bubble. The sample in the cycle after completion is sample 1 of the next window.
- WAIT exit: counts update and countsValid stays 1 on the cycle after the handshake. The first new sample is taken one cycle after WAIT exit.
- Accept and load on the same edge: the new value replaces the old one and countsValid stays 1.
- rst asserted mid-window: everything returns to reset values immediately. The partial window and any unconsumed result are discarded.
- busy is combinational from state only.

## Structure
- Shared package sc_pkg:
  - state enum (IDLE/ACCUM/WAIT);
  - CW derivation helper.
- Sub-module sc_bit_counter: one CW-bit accumulator with clear, enable and bit input, instantiated NUM_STREAMS times in a generate loop.
- The top level holds the FSM, the shared sample counter, the output register and the overrun flag.

## Test plan
- NUM_STREAMS=4, LOG_WINDOW=4, continuous=0. start, then 16 valid samples with stream0 all 1, stream1 all 0, stream2 alternating, stream3 1 on 3 samples -> counts {16,0,8,3}, countsValid=1 one cycle after the 16th sample, state returns to IDLE.
- Same window with inValid low on every other cycle -> identical counts, completion after 31 cycles.
- continuous=1, countsReady tied 1, two back-to-back windows of all-1 then all-0 on stream0 -> 16 then 0, no idle cycle between windows.
- continuous=1, countsReady=0 through two full windows -> block enters WAIT and further inValid sets overrun. Raise countsReady -> first result accepted, second result appears the next cycle with countsValid continuously 1.
- rst pulsed after 7 samples -> all outputs 0 and IDLE. A new start plus 16 all-1 samples gives 16, with no residue from the aborted window.
- start asserted while in ACCUM -> ignored; the window completes at the original sample count.
